// File: rtl/conv_layer_ctrl.sv
// conv_layer_ctrl: sequencer for one convolution layer.
// Preloads the pixel/weight buffers, then steps the systolic array through
// WGT_SETS weight matrices per frame, WIN windows per matrix, K2 slots per pass.
// Every enable/strobe is registered and reflects the state/counters of the
// previous cycle. Slot and window position are tracked by wrap-around
// sub-counters so no dividers are needed.
//
// Handshake: sta is a start pulse sampled only in IDLE (ignored elsewhere);
// busy is high whenever the state is not IDLE; done is a one-cycle pulse
// that coincides with the single DONE cycle, after which busy falls and sta
// is accepted again. stall holds all sequencing in RUN only and forces every
// enable/strobe low for the following cycle; it has no effect in other states.
module conv_layer_ctrl #(
    parameter int K2       = 9,
    parameter int BUB      = 2,
    parameter int WIN      = 2,
    parameter int WGT_SETS = 32,
    parameter int PIX_LOAD = 300,
    parameter int FRAMES   = 0,
    localparam int PERIOD  = WGT_SETS * WIN * K2,
    localparam int IW      = $clog2(PIX_LOAD + 1),
    localparam int DW      = $clog2(PERIOD),
    localparam int NW      = $clog2(WGT_SETS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sta,
    input  logic          stall,
    output logic [1:0]    state,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] init_cnt,
    output logic [DW-1:0] data_cnt,
    output logic [15:0]   frame_cnt,
    output logic          en_array,
    output logic          en_cnt,
    output logic          en_DFF_pixel,
    output logic          en_DFF_weight,
    output logic          ud_pixel,
    output logic          ud_weight,
    output logic          flush,
    output logic          valid_o,
    output logic [NW-1:0] weight_num
);

    localparam int SW = $clog2(K2);
    // One extra bit so that K2 itself is representable when WIN == 1.
    localparam int PW = $clog2(WIN * K2 + 1);

    localparam logic [IW-1:0] INIT_LAST  = IW'(PIX_LOAD);
    localparam logic [IW-1:0] INIT_UD    = IW'(PIX_LOAD - 1);
    localparam logic [IW-1:0] INIT_K2    = IW'(K2);
    localparam logic [DW-1:0] DATA_LAST  = DW'(PERIOD - 1);
    localparam logic [DW-1:0] DATA_UD    = DW'(PERIOD - 2);
    localparam logic [DW-1:0] DATA_PIX   = DW'(PIX_LOAD);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(K2 - 1);
    localparam logic [SW-1:0] SLOT_VALID = SW'(K2 - 2);
    localparam logic [SW-1:0] SLOT_BUB   = SW'(K2 - 1 - BUB);
    localparam logic [PW-1:0] WPOS_LAST  = PW'(WIN * K2 - 1);
    localparam logic [PW-1:0] WPOS_UD    = PW'(WIN * K2 - 2);
    localparam logic [PW-1:0] WPOS_K2    = PW'(K2);
    localparam logic [NW-1:0] WN_LAST    = NW'(WGT_SETS - 1);
    localparam logic [15:0]   FRAME_LAST = 16'(FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] init_q, init_d;
    logic [DW-1:0] data_q, data_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [PW-1:0] wpos_q, wpos_d;
    logic [15:0]   frame_q, frame_d;
    logic [NW-1:0] wn_q, wn_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          en_array_q, en_array_d;
    logic          en_dff_pixel_q, en_dff_pixel_d;
    logic          en_dff_weight_q, en_dff_weight_d;
    logic          ud_pixel_q, ud_pixel_d;
    logic          ud_weight_q, ud_weight_d;
    logic          flush_q, flush_d;
    logic          valid_q, valid_d;

    // Next-state, counter and registered-decode computation.
    always_comb begin
        state_d         = state_q;
        init_d          = init_q;
        data_d          = data_q;
        slot_d          = slot_q;
        wpos_d          = wpos_q;
        frame_d         = frame_q;
        wn_d            = wn_q;
        en_array_d      = 1'b0;
        en_dff_pixel_d  = 1'b0;
        en_dff_weight_d = 1'b0;
        ud_pixel_d      = 1'b0;
        ud_weight_d     = 1'b0;
        flush_d         = 1'b0;
        valid_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Parked on the last matrix so the first RUN pass advances to 0.
                wn_d = WN_LAST;
                if (sta) begin
                    state_d = S_LOAD;
                    init_d  = '0;
                    frame_d = '0;  // frame count restarts with each run
                end
            end
            S_LOAD: begin
                wn_d            = WN_LAST;
                en_dff_pixel_d  = (init_q < INIT_LAST);
                en_dff_weight_d = (init_q < INIT_K2);
                ud_pixel_d      = (init_q == INIT_UD);
                ud_weight_d     = (init_q == INIT_UD);
                en_array_d      = (init_q == INIT_LAST);
                if (init_q == INIT_LAST) begin
                    state_d = S_RUN;
                    data_d  = '0;
                    slot_d  = '0;
                    wpos_d  = '0;
                end else begin
                    init_d = init_q + IW'(1);
                end
            end
            S_RUN: begin
                if (!stall) begin
                    en_array_d      = (slot_q < SLOT_BUB) || (slot_q == SLOT_LAST);
                    flush_d         = (slot_q == SLOT_LAST);
                    valid_d         = (slot_q == SLOT_VALID);
                    en_dff_pixel_d  = (data_q < DATA_PIX);
                    en_dff_weight_d = (wpos_q < WPOS_K2);
                    ud_weight_d     = (wpos_q == WPOS_UD);
                    ud_pixel_d      = (data_q == DATA_UD);
                    if (wpos_q == '0) begin
                        wn_d = (wn_q == WN_LAST) ? '0 : wn_q + NW'(1);
                    end
                    slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
                    wpos_d = (wpos_q == WPOS_LAST) ? '0 : wpos_q + PW'(1);
                    if (data_q == DATA_LAST) begin
                        data_d  = '0;
                        frame_d = frame_q + 16'd1;
                        if ((FRAMES != 0) && (frame_q == FRAME_LAST)) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        data_d = data_q + DW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, counters and registered outputs; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            init_q          <= '0;
            data_q          <= '0;
            slot_q          <= '0;
            wpos_q          <= '0;
            frame_q         <= '0;
            wn_q            <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            en_array_q      <= 1'b0;
            en_dff_pixel_q  <= 1'b0;
            en_dff_weight_q <= 1'b0;
            ud_pixel_q      <= 1'b0;
            ud_weight_q     <= 1'b0;
            flush_q         <= 1'b0;
            valid_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            init_q          <= init_d;
            data_q          <= data_d;
            slot_q          <= slot_d;
            wpos_q          <= wpos_d;
            frame_q         <= frame_d;
            wn_q            <= wn_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            en_array_q      <= en_array_d;
            en_dff_pixel_q  <= en_dff_pixel_d;
            en_dff_weight_q <= en_dff_weight_d;
            ud_pixel_q      <= ud_pixel_d;
            ud_weight_q     <= ud_weight_d;
            flush_q         <= flush_d;
            valid_q         <= valid_d;
        end
    end

    assign state         = state_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign init_cnt      = init_q;
    assign data_cnt      = data_q;
    assign frame_cnt     = frame_q;
    assign en_array      = en_array_q;
    assign en_cnt        = en_array_q;
    assign en_DFF_pixel  = en_dff_pixel_q;
    assign en_DFF_weight = en_dff_weight_q;
    assign ud_pixel      = ud_pixel_q;
    assign ud_weight     = ud_weight_q;
    assign flush         = flush_q;
    assign valid_o       = valid_q;
    assign weight_num    = wn_q;

endmodule
